// File: rtl/bp_me_nonsynth_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : bp_me_nonsynth_mem_responder
// Brief   : BedRock Stream memory model, one outstanding command, fixed latency
// Revision: 1.0
// ============================================================================

package bp_me_nonsynth_mem_responder_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  localparam int PADDR_WIDTH = 40;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [15:0]             payload;
    bp_bedrock_msg_size_e    size;
    logic [PADDR_WIDTH-1:0]  addr;
    bp_bedrock_mem_type_e    msg_type;
  } bp_bedrock_mem_header_s;

  localparam int HDR_ADDR_LSB = $bits(bp_bedrock_mem_type_e);
  localparam int HDR_SIZE_LSB = HDR_ADDR_LSB + PADDR_WIDTH;

  function automatic int bp_data_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 64;
      default:          return 64;
    endcase
  endfunction

endpackage

module bp_me_nonsynth_mem_responder
  import bp_me_nonsynth_mem_responder_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int mem_els_p = 256,
  parameter int latency_p = 4,
  localparam int bedrock_data_width_p = bp_data_width(bp_params_p),
  localparam int mem_header_width_lp = $bits(bp_bedrock_mem_header_s)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [mem_header_width_lp-1:0]  mem_cmd_header_i,
  input  logic [bedrock_data_width_p-1:0] mem_cmd_data_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_ready_and_o,
  input  logic                            mem_cmd_last_i,
  output logic [mem_header_width_lp-1:0]  mem_resp_header_o,
  output logic [bedrock_data_width_p-1:0] mem_resp_data_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_ready_and_i,
  output logic                            mem_resp_last_o
);

  localparam int BYTES = bedrock_data_width_p / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(mem_els_p);
  localparam int LO_W  = OFF_W + IDX_W;
  localparam int CNT_W = $clog2(128 / BYTES) + 1;
  localparam int LAT_W = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

  typedef enum logic [1:0] {e_ready, e_write, e_delay, e_resp} state_e;

  function automatic logic [2:0] lg_beats(input logic [2:0] size);
    return (32'(size) >= OFF_W) ? 3'(32'(size) - OFF_W) : 3'd0;
  endfunction

  // Critical-word-first: only the low lg(N) index bits rotate, upper bits fixed
  function automatic logic [IDX_W-1:0] beat_idx(input logic [IDX_W-1:0] word,
                                                 input logic [2:0]       lgn,
                                                 input logic [CNT_W-1:0] k);
    logic [IDX_W-1:0] mask;
    mask = IDX_W'((32'd1 << lgn) - 32'd1);
    return (word & ~mask) | ((word + IDX_W'(k)) & mask);
  endfunction

  state_e                          r_state;
  bp_bedrock_mem_header_s          r_hdr;
  logic [bedrock_data_width_p-1:0] r_mem [mem_els_p];
  logic [CNT_W-1:0]                r_cmd_beat;
  logic [CNT_W-1:0]                r_resp_beat;
  logic [LAT_W-1:0]                r_lat;
  logic                            r_resp_v;
  logic                            r_resp_last;
  logic [bedrock_data_width_p-1:0] r_resp_data;

  logic                            w_in_ready;
  logic                            w_cmd_fire;
  logic                            w_resp_fire;
  logic [3:0]                      w_type;
  logic [2:0]                      w_size;
  logic [LO_W-1:0]                 w_addr_lo;
  logic                            w_is_wr;
  logic [CNT_W-1:0]                w_cmd_k;
  logic [CNT_W-1:0]                w_cmd_n;
  logic [IDX_W-1:0]                w_wr_idx;
  logic [BYTES-1:0]                w_wr_mask;
  logic [bedrock_data_width_p-1:0] w_wr_data;
  logic                            w_rd_is_read;
  logic [CNT_W-1:0]                w_resp_n;
  logic [CNT_W-1:0]                w_resp_k;
  logic [IDX_W-1:0]                w_rd_idx;

  assign mem_cmd_ready_and_o = ~reset_i & ((r_state == e_ready) | (r_state == e_write));
  assign w_cmd_fire  = mem_cmd_ready_and_o & mem_cmd_v_i;
  assign w_resp_fire = r_resp_v & mem_resp_ready_and_i;

  // The header travels with beat 0; later beats use the captured copy
  assign w_in_ready = (r_state == e_ready);
  assign w_type    = w_in_ready ? mem_cmd_header_i[3:0] : r_hdr.msg_type;
  assign w_size    = w_in_ready ? mem_cmd_header_i[HDR_SIZE_LSB +: 3] : r_hdr.size;
  assign w_addr_lo = w_in_ready ? mem_cmd_header_i[HDR_ADDR_LSB +: LO_W] : r_hdr.addr[LO_W-1:0];
  assign w_is_wr   = (w_type == e_bedrock_mem_wr) || (w_type == e_bedrock_mem_uc_wr);
  assign w_cmd_k   = w_in_ready ? '0 : r_cmd_beat;
  assign w_cmd_n   = CNT_W'(1) << lg_beats(w_size);
  assign w_wr_idx  = beat_idx(w_addr_lo[LO_W-1:OFF_W], lg_beats(w_size), w_cmd_k);

  always_comb begin
    w_wr_mask = '1;
    w_wr_data = mem_cmd_data_i;
    if (32'(w_size) < OFF_W) begin
      w_wr_mask = BYTES'(((32'd1 << (32'd1 << w_size)) - 32'd1) << w_addr_lo[OFF_W-1:0]);
      w_wr_data = mem_cmd_data_i << (8 * w_addr_lo[OFF_W-1:0]);
    end
  end

  assign w_rd_is_read = (r_hdr.msg_type == e_bedrock_mem_rd) || (r_hdr.msg_type == e_bedrock_mem_uc_rd);
  assign w_resp_n     = w_rd_is_read ? (CNT_W'(1) << lg_beats(r_hdr.size)) : CNT_W'(1);
  assign w_resp_k     = (r_state == e_delay) ? '0 : (r_resp_beat + CNT_W'(1));
  assign w_rd_idx     = beat_idx(r_hdr.addr[LO_W-1:OFF_W], lg_beats(r_hdr.size), w_resp_k);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= e_ready;
      r_hdr       <= '0;
      r_cmd_beat  <= '0;
      r_resp_beat <= '0;
      r_lat       <= '0;
      r_resp_v    <= 1'b0;
      r_resp_last <= 1'b0;
      r_resp_data <= '0;
      for (int i = 0; i < mem_els_p; i++) r_mem[i] <= '0;
    end else begin
      if (w_cmd_fire && w_is_wr) begin
        for (int b = 0; b < BYTES; b++)
          if (w_wr_mask[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
      unique case (r_state)
        e_ready: if (w_cmd_fire) begin
          r_hdr      <= mem_cmd_header_i;
          r_cmd_beat <= CNT_W'(1);
          if (mem_cmd_last_i) begin
            r_state <= e_delay;
            r_lat   <= LAT_W'(latency_p);
          end else begin
            r_state <= e_write;
          end
        end
        e_write: if (w_cmd_fire) begin
          r_cmd_beat <= r_cmd_beat + CNT_W'(1);
          if (mem_cmd_last_i) begin
            r_state <= e_delay;
            r_lat   <= LAT_W'(latency_p);
          end
        end
        e_delay: begin
          if (r_lat == '0) begin
            r_state     <= e_resp;
            r_resp_v    <= 1'b1;
            r_resp_beat <= '0;
            r_resp_last <= (w_resp_n == CNT_W'(1));
            r_resp_data <= w_rd_is_read ? r_mem[w_rd_idx] : '0;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        e_resp: if (w_resp_fire) begin
          if (r_resp_last) begin
            r_state     <= e_ready;
            r_resp_v    <= 1'b0;
            r_resp_last <= 1'b0;
            r_resp_data <= '0;
          end else begin
            r_resp_beat <= r_resp_beat + CNT_W'(1);
            r_resp_data <= r_mem[w_rd_idx];
            r_resp_last <= ((r_resp_beat + CNT_W'(2)) == w_resp_n);
          end
        end
        default: r_state <= e_ready;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && (r_state == e_write) && w_cmd_fire && mem_cmd_last_i)
      assert ((r_cmd_beat + CNT_W'(1)) == w_cmd_n)
        else $error("mem cmd last beat at count %0d, expected %0d", r_cmd_beat + CNT_W'(1), w_cmd_n);
  end

  assign mem_resp_header_o = r_hdr;
  assign mem_resp_data_o   = r_resp_data;
  assign mem_resp_v_o      = r_resp_v;
  assign mem_resp_last_o   = r_resp_last;

endmodule

`default_nettype wire

// File: doc/bp_me_nonsynth_mem_responder.md
BP_ME_NONSYNTH_MEM_RESPONDER -- requirements
Module: bp_me_nonsynth_mem_responder

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg, selecting the BedRock processor configuration (paddr, data and block widths).
REQ-002 SHALL have parameter mem_els_p, default 256, giving the number of bedrock_data_width_p-bit storage words.
REQ-003 SHALL have parameter latency_p, default 4, giving the fixed response delay in cycles; 0 is legal.
REQ-004 clk_i  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 mem_cmd_header_i  input  mem_header_width_lp  BedRock mem command header.
REQ-007 mem_cmd_data_i  input  bedrock_data_width_p  command data beat.
REQ-008 mem_cmd_v_i  input  1  command beat valid.
REQ-009 mem_cmd_ready_and_o  output  1  command beat accepted when high with mem_cmd_v_i.
REQ-010 mem_cmd_last_i  input  1  final beat of the command.
REQ-011 mem_resp_header_o  output  mem_header_width_lp  response header.
REQ-012 mem_resp_data_o  output  bedrock_data_width_p  response data beat.
REQ-013 mem_resp_v_o  output  1  response beat valid.
REQ-014 mem_resp_ready_and_i  input  1  response beat consumed when high with mem_resp_v_o.
REQ-015 mem_resp_last_o  output  1  final response beat.

Function
REQ-016 Both mem ports SHALL follow BedRock Stream ready&valid: beat transfers iff v & ready_and on a rising edge; header is held constant across all beats of one message.
REQ-017 The FSM SHALL have four states: READY, WRITE, DELAY, RESP, and SHALL hold at most one outstanding command.
REQ-018 mem_cmd_ready_and_o SHALL be 1 in READY and WRITE, 0 in DELAY and RESP.
REQ-019 Word index SHALL be addr[lg(bedrock_data_width_p/8) +: lg(mem_els_p)]; beat count N = max(1, 2^size*8/bedrock_data_width_p).
REQ-020 In READY, an accepted beat SHALL capture the header; with last=1 the FSM goes to DELAY, otherwise to WRITE.
REQ-021 Every accepted beat of e_bedrock_mem_wr/e_bedrock_mem_uc_wr SHALL write storage on that edge; beat k targets word index with its low lg(N) bits replaced by (start+k) mod N.
REQ-022 Writes with 2^size smaller than a beat SHALL update only the 2^size bytes at the address byte offset, taken from the data LSBs.
REQ-023 In WRITE, the accepted beat carrying last=1 SHALL move the FSM to DELAY; a last beat arriving at beat count != N SHALL raise $error.
REQ-024 DELAY SHALL load a counter with latency_p on entry; mem_resp_v_o SHALL first assert exactly latency_p+1 cycles after the last command-beat handshake.
REQ-025 In RESP, mem_resp_header_o SHALL equal the captured command header, unmodified (msg_type, addr, size, payload).
REQ-026 Reads (e_bedrock_mem_rd, e_bedrock_mem_uc_rd) SHALL return N beats, critical-word-first: beat k = storage[index with low lg(N) bits = (start+k) mod N].
REQ-027 Writes and all other msg types SHALL return a single beat with data 0 and no storage effect beyond REQ-021.
REQ-028 mem_resp_last_o SHALL be 1 only on the final response beat; its handshake returns the FSM to READY.
REQ-029 While mem_resp_ready_and_i is low, header, data, last and v SHALL remain stable; no beat is skipped or repeated.
REQ-030 A new command SHALL be accepted no earlier than the cycle after the final response handshake.
REQ-031 Addresses beyond mem_els_p words SHALL alias modulo mem_els_p.

Reset
REQ-032 While reset_i is high: FSM=READY, counters=0, mem_resp_v_o=0, mem_resp_last_o=0, mem_cmd_ready_and_o=0, mem_resp_header_o=0, mem_resp_data_o=0, all storage words=0.
REQ-033 Reset asserted mid-command or mid-response SHALL abandon the transaction; mem_cmd_ready_and_o=1 in the first cycle after reset deasserts.

Verification (64-bit beats, 512-bit block, N=8, latency_p=4)
REQ-034 Block wr addr 0x8000_0040, data 1..8 -> single zero-data ack with last=1, 5 cycles after last beat; block rd same addr -> beats 1..8, last on beat 8, header echoed.
REQ-035 Block rd addr 0x8000_0058 after REQ-034 -> beats 4,5,6,7,8,1,2,3.
REQ-036 uc_wr size 4B addr 0x8000_0014 data 0xDEADBEEF over zeroed word -> uc_rd size 8B addr 0x8000_0010 returns 0xDEADBEEF_00000000, one beat, last=1.
REQ-037 Deassert mem_resp_ready_and_i 3 cycles during beat 3 of a read -> all outputs stable; 8 beats total delivered in order.
REQ-038 Reset during read after beat 2 -> mem_resp_v_o=0 next cycle; a subsequent read of 0x8000_0040 returns eight zero beats.
REQ-039 Unsupported msg type (e.g. e_bedrock_mem_pre) -> one beat, data 0, last=1, storage unchanged.
